// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch unit with a small in-order fetch queue.
// Issues one instruction-memory read at a time from the fetch PC, turns
// out-of-range or misaligned fetch addresses into address-error entries
// without touching memory, and flushes and restarts on redirect.
//
// Optional feature: define IFU_BYPASS_EN to let a response that arrives while
// the queue is empty appear on out_* in the same cycle as mem_ack.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; may issue or enqueue an address error
// WAIT  | request for fpc outstanding; its response will be enqueued
// DROP  | request outstanding but made stale by a redirect; discard it
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter logic [31:0] TEXT_LO  = 32'h00003000,
    parameter logic [31:0] TEXT_HI  = 32'h00004fff,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [31:0]   fpc_q,      fpc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;

    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic          q_adel_q  [DEPTH];

    logic          fpc_err;
    logic          q_valid;
    logic          enq;
    logic          deq;
    logic          flush;
    logic [31:0]   enq_instr;
    logic          enq_adel;
`ifdef IFU_BYPASS_EN
    logic          byp_valid;
`endif

    assign fpc_err = (fpc_q[1:0] != 2'b00) || (fpc_q < TEXT_LO) || (fpc_q > TEXT_HI);
    assign q_valid = (count_q != '0);
    assign deq     = q_valid && out_ready;

    // The request stays up with the address captured at issue time, so a
    // redirect while it is outstanding cannot disturb the memory handshake.
    assign mem_req  = (state_q != S_IDLE);
    assign mem_addr = req_addr_q;

    // Next-state: FSM transitions, fetch PC update and queue write request.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        enq        = 1'b0;
        enq_instr  = '0;
        enq_adel   = 1'b0;
        flush      = 1'b0;
`ifdef IFU_BYPASS_EN
        byp_valid  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    flush = 1'b1;
                    fpc_d = redirect_pc;
                end else if (count_q < DEPTH_C) begin
                    if (fpc_err) begin
                        enq      = 1'b1;
                        enq_adel = 1'b1;
                        fpc_d    = fpc_q + 32'd4;
                    end else begin
                        state_d    = S_WAIT;
                        req_addr_d = fpc_q;
                    end
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    flush   = 1'b1;
                    fpc_d   = redirect_pc;
                    state_d = mem_ack ? S_IDLE : S_DROP;
                end else if (mem_ack) begin
                    state_d   = S_IDLE;
                    fpc_d     = fpc_q + 32'd4;
                    enq       = 1'b1;
                    enq_instr = mem_rdata;
`ifdef IFU_BYPASS_EN
                    if (!q_valid) begin
                        byp_valid = 1'b1;
                        enq       = !out_ready;
                    end
`endif
                end
            end
            S_DROP: begin
                if (redirect) begin
                    flush = 1'b1;
                    fpc_d = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next-state: queue pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State register for the FSM, fetch PC and queue bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fpc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful under count_q, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc_q[wr_ptr_q]    <= fpc_q;
            q_instr_q[wr_ptr_q] <= enq_instr;
            q_adel_q[wr_ptr_q]  <= enq_adel;
        end
    end

    // Head of queue drives the decode interface; all zeros when empty.
    always_comb begin
        out_valid = q_valid;
        out_pc    = '0;
        out_instr = '0;
        out_adel  = 1'b0;
        if (q_valid) begin
            out_pc    = q_pc_q[rd_ptr_q];
            out_instr = q_instr_q[rd_ptr_q];
            out_adel  = q_adel_q[rd_ptr_q];
        end
`ifdef IFU_BYPASS_EN
        if (byp_valid) begin
            out_valid = 1'b1;
            out_pc    = fpc_q;
            out_instr = mem_rdata;
            out_adel  = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed testbench for ifu_prefetch (default parameters).
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    int checks = 0;
    int errors = 0;
    logic [31:0] a;

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_adel    (out_adel)
    );

    function automatic logic [31:0] rd(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        out_ready   = 1'b1;
        step;
        step;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        reset = 1'b0;

        // Sequential fetch with a one-cycle memory, decode always ready
        step;
        for (int i = 0; i < 3; i++) begin
            a = 32'h3000 + 32'(4 * i);
            chk1("seq_req", mem_req, 1'b1);
            chk("seq_addr", mem_addr, a);
            mem_ack   = 1'b1;
            mem_rdata = rd(a);
            step;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            chk1("seq_req_low", mem_req, 1'b0);
            chk1("seq_valid", out_valid, 1'b1);
            chk("seq_pc", out_pc, a);
            chk("seq_instr", out_instr, rd(a));
            chk1("seq_adel", out_adel, 1'b0);
            step;
        end
        chk1("seq_drained", out_valid, 1'b0);
        chk("seq_next_addr", mem_addr, 32'h300c);

        // Reset while a request is outstanding; acks around reset are ignored
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0bad;
        step;
        chk1("midwait_rst_req", mem_req, 1'b0);
        chk1("midwait_rst_valid", out_valid, 1'b0);
        reset = 1'b0;
        step;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk1("stray_ack_no_enq", out_valid, 1'b0);
        chk1("post_rst_req", mem_req, 1'b1);
        chk("post_rst_addr", mem_addr, 32'h3000);

        // Fill the queue with decode stalled, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + 32'(4 * i);
            chk1("fill_req", mem_req, 1'b1);
            chk("fill_addr", mem_addr, a);
            mem_ack   = 1'b1;
            mem_rdata = rd(a);
            step;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            step;
        end
        chk1("full_no_issue", mem_req, 1'b0);
        step;
        step;
        chk1("full_no_issue_hold", mem_req, 1'b0);
        chk("full_head", out_pc, 32'h3000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + 32'(4 * i);
            chk1("drain_valid", out_valid, 1'b1);
            chk("drain_pc", out_pc, a);
            chk("drain_instr", out_instr, rd(a));
            step;
        end
        chk1("drain_empty", out_valid, 1'b0);
        chk1("drain_refetch_req", mem_req, 1'b1);
        chk("drain_refetch_addr", mem_addr, 32'h3010);

        // Redirect while waiting: request held, late ack discarded
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4180;
        step;
        redirect = 1'b0;
        chk1("drop_req_hold", mem_req, 1'b1);
        chk("drop_addr_hold", mem_addr, 32'h3010);
        chk1("drop_flushed", out_valid, 1'b0);
        step;
        chk("drop_addr_hold2", mem_addr, 32'h3010);
        mem_ack   = 1'b1;
        mem_rdata = rd(32'h3010);
        step;
        mem_ack = 1'b0;
        chk1("drop_discard", out_valid, 1'b0);
        chk1("drop_req_low", mem_req, 1'b0);
        step;
        chk1("redir_req", mem_req, 1'b1);
        chk("redir_addr", mem_addr, 32'h4180);
        mem_ack   = 1'b1;
        mem_rdata = rd(32'h4180);
        step;
        mem_ack = 1'b0;
        chk1("redir_valid", out_valid, 1'b1);
        chk("redir_pc", out_pc, 32'h4180);
        chk("redir_instr", out_instr, rd(32'h4180));

        // Redirect coincident with ack
        step;
        chk("coinc_pre_addr", mem_addr, 32'h4184);
        chk1("coinc_pre_valid", out_valid, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3100;
        mem_ack     = 1'b1;
        mem_rdata   = rd(32'h4184);
        step;
        redirect = 1'b0;
        mem_ack  = 1'b0;
        chk1("coinc_no_enq", out_valid, 1'b0);
        chk1("coinc_req_low", mem_req, 1'b0);
        step;
        chk1("coinc_req", mem_req, 1'b1);
        chk("coinc_addr", mem_addr, 32'h3100);
        mem_ack   = 1'b1;
        mem_rdata = rd(32'h3100);
        step;
        mem_ack = 1'b0;
        chk1("coinc_valid", out_valid, 1'b1);
        chk("coinc_pc", out_pc, 32'h3100);

        // Misaligned and out-of-range fetch addresses
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3002;
        step;
        redirect  = 1'b0;
        out_ready = 1'b0;
        chk1("mis_flushed", out_valid, 1'b0);
        chk1("mis_flush_req", mem_req, 1'b0);
        step;
        chk1("mis_valid", out_valid, 1'b1);
        chk("mis_pc", out_pc, 32'h3002);
        chk("mis_instr", out_instr, 32'h0);
        chk1("mis_adel", out_adel, 1'b1);
        chk1("mis_no_req", mem_req, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        step;
        redirect = 1'b0;
        chk1("oor_flushed", out_valid, 1'b0);
        step;
        chk("oor_pc", out_pc, 32'h5000);
        chk1("oor_adel", out_adel, 1'b1);
        chk("oor_instr", out_instr, 32'h0);
        chk1("oor_no_req", mem_req, 1'b0);

        // Response on empty queue with decode ready: bypass vs registered
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3200;
        out_ready   = 1'b1;
        step;
        redirect = 1'b0;
        chk1("byp_flushed", out_valid, 1'b0);
        step;
        chk1("byp_req", mem_req, 1'b1);
        chk("byp_addr", mem_addr, 32'h3200);
        chk1("byp_pre_valid", out_valid, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = rd(32'h3200);
        #1;
`ifdef IFU_BYPASS_EN
        chk1("byp_same_valid", out_valid, 1'b1);
        chk("byp_same_pc", out_pc, 32'h3200);
        chk("byp_same_instr", out_instr, rd(32'h3200));
`else
        chk1("byp_same_valid", out_valid, 1'b0);
`endif
        step;
        mem_ack = 1'b0;
`ifdef IFU_BYPASS_EN
        chk1("byp_next_valid", out_valid, 1'b0);
`else
        chk1("byp_next_valid", out_valid, 1'b1);
        chk("byp_next_pc", out_pc, 32'h3200);
        chk("byp_next_instr", out_instr, rd(32'h3200));
`endif
        step;
        chk1("byp_after_req", mem_req, 1'b1);
        chk("byp_after_addr", mem_addr, 32'h3204);
        chk1("byp_after_valid", out_valid, 1'b0);

        // Top of the legal text range, then the first address past it
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4ffc;
        step;
        redirect = 1'b0;
        chk("hi_drop_addr", mem_addr, 32'h3204);
        mem_ack   = 1'b1;
        mem_rdata = rd(32'h3204);
        step;
        mem_ack = 1'b0;
        chk1("hi_drop_req", mem_req, 1'b0);
        chk1("hi_drop_valid", out_valid, 1'b0);
        step;
        chk1("hi_req", mem_req, 1'b1);
        chk("hi_addr", mem_addr, 32'h4ffc);
        out_ready = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = rd(32'h4ffc);
        step;
        mem_ack = 1'b0;
        chk("hi_pc", out_pc, 32'h4ffc);
        chk1("hi_adel", out_adel, 1'b0);
        chk("hi_instr", out_instr, rd(32'h4ffc));
        step;
        chk("hi_head_hold", out_pc, 32'h4ffc);
        chk1("hi_next_no_req", mem_req, 1'b0);
        out_ready = 1'b1;
        step;
        chk("past_hi_pc", out_pc, 32'h5000);
        chk1("past_hi_adel", out_adel, 1'b1);
        chk("past_hi_instr", out_instr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
